demux: RTL and testbench

DEMUX -- requirements
Module: demux

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux.sv | 86 ++++++++
 tb/tb_demux.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and slot-tag constants for the nibble-stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A   = 2'b01;
  localparam logic [1:0] SEL_B   = 2'b10;
  localparam logic [1:0] SEL_C   = 2'b00;
  localparam logic [1:0] SEL_BAD = 2'b11;

  // Rotation A -> B -> C -> A; anything else restarts at A.
  function automatic logic [1:0] next_tag(input logic [1:0] tag);
    logic [1:0] nxt;
    nxt = SEL_A;
    case (tag)
      SEL_A:   nxt = SEL_B;
      SEL_B:   nxt = SEL_C;
      default: nxt = SEL_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/demux.sv
// Three-slot time-multiplexed nibble demultiplexer with rotation tracking and
// atomic frame commit of slots A/B/C.
module demux
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic [1:0] sel_in,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [3:0] out_c,
  output logic       frame_valid,
  output logic       locked,
  output logic       seq_err,
  output logic [7:0] frame_cnt
);

  state_t     state_q;
  logic [1:0] exp_q;
  logic [3:0] sh_a_q;
  logic [3:0] sh_b_q;
  logic [3:0] out_a_q;
  logic [3:0] out_b_q;
  logic [3:0] out_c_q;
  logic       fv_q;
  logic       err_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= SEL_A;
      sh_a_q  <= 4'd0;
      sh_b_q  <= 4'd0;
      out_a_q <= 4'd0;
      out_b_q <= 4'd0;
      out_c_q <= 4'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      fv_q  <= 1'b0;
      err_q <= 1'b0;
      if (state_q == HUNT) begin
        // Only a slot-A tag can start a frame; everything else is silently dropped.
        if (sel_in == SEL_A) begin
          sh_a_q  <= data_in;
          exp_q   <= SEL_B;
          state_q <= LOCK;
        end
      end else begin
        if (sel_in != exp_q) begin
          err_q   <= 1'b1;
          state_q <= HUNT;
          exp_q   <= SEL_A;
          sh_a_q  <= 4'd0;
          sh_b_q  <= 4'd0;
        end else begin
          exp_q <= next_tag(exp_q);
          case (sel_in)
            SEL_A:   sh_a_q <= data_in;
            SEL_B:   sh_b_q <= data_in;
            default: begin
              // Slot C closes the frame: all three outputs update together.
              out_a_q <= sh_a_q;
              out_b_q <= sh_b_q;
              out_c_q <= data_in;
              fv_q    <= 1'b1;
              cnt_q   <= cnt_q + 8'd1;
            end
          endcase
        end
      end
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_c       = out_c_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == LOCK);
  assign seq_err     = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_demux.sv
// Scoreboard bench for demux: stimulus pushes expected commits, a negedge
// monitor pops them on frame_valid and polices pulses and atomicity.
module tb_demux;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic [1:0] sel_in;
  logic [3:0] out_a, out_b, out_c;
  logic       frame_valid, locked, seq_err;
  logic [7:0] frame_cnt;

  demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .sel_in      (sel_in),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .frame_valid (frame_valid),
    .locked      (locked),
    .seq_err     (seq_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_seen = 0;
  int         fv_seen = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every commit and checks per-cycle rules.
  logic [11:0] prev_outs;
  initial prev_outs = 12'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_outs <= {out_a, out_b, out_c};
    end else begin
      if (seq_err) err_seen++;
      if (frame_valid) fv_seen++;
      chk("fv_err_exclusive", {31'd0, frame_valid & seq_err}, 32'd0);
      if (!frame_valid)
        chk("atomic_hold", {20'd0, out_a, out_b, out_c}, {20'd0, prev_outs});
      if (frame_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_commit", {20'd0, out_a, out_b, out_c}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("commit_outs", {20'd0, out_a, out_b, out_c}, {20'd0, e.a, e.b, e.c});
          chk("commit_cnt", {24'd0, frame_cnt}, {24'd0, e.cnt});
        end
      end
      prev_outs <= {out_a, out_b, out_c};
    end
  end

  task automatic drive(input logic [1:0] s, input logic [3:0] d);
    sel_in  = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_t e;
    drive(2'b01, a);
    drive(2'b10, b);
    exp_cnt = exp_cnt + 8'd1;
    e.a = a; e.b = b; e.c = c; e.cnt = exp_cnt;
    sbq.push_back(e);
    drive(2'b00, c);
  endtask

  int err_base;
  int fv_base;

  initial begin
    rst_n   = 1'b0;
    sel_in  = 2'b11;
    data_in = 4'd0;
    #12;
    chk("rst_outs", {20'd0, out_a, out_b, out_c}, 32'd0);
    chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_flags", {29'd0, frame_valid, seq_err, locked}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    settle();

    // Nominal: three frames of 3/7/9.
    for (int i = 0; i < 3; i++) frame(4'd3, 4'd7, 4'd9);
    settle();
    chk("nom_cnt", {24'd0, frame_cnt}, 32'd3);
    chk("nom_locked", {31'd0, locked}, 32'd1);
    chk("nom_fv_count", fv_seen, 32'd3);
    chk("nom_no_err", err_seen, 32'd0);

    // Misorder: A then C while expecting B.
    err_base = err_seen;
    drive(2'b01, 4'd1);
    drive(2'b00, 4'd2);
    settle();
    chk("mis_err", err_seen - err_base, 32'd1);
    chk("mis_locked", {31'd0, locked}, 32'd0);
    chk("mis_outs_hold", {20'd0, out_a, out_b, out_c}, 32'h379);
    chk("mis_cnt_hold", {24'd0, frame_cnt}, 32'd3);
    frame(4'd4, 4'd5, 4'd6);
    settle();
    chk("rec_outs", {20'd0, out_a, out_b, out_c}, 32'h456);
    chk("rec_cnt", {24'd0, frame_cnt}, 32'd4);

    // Illegal tag while locked, then repeated in HUNT.
    err_base = err_seen;
    drive(2'b11, 4'd0);
    settle();
    chk("bad_err", err_seen - err_base, 32'd1);
    chk("bad_locked", {31'd0, locked}, 32'd0);
    drive(2'b11, 4'd0);
    drive(2'b11, 4'd0);
    settle();
    chk("bad_hunt_no_err", err_seen - err_base, 32'd1);
    chk("bad_hunt_locked", {31'd0, locked}, 32'd0);

    // Reset mid-frame: outputs clear asynchronously, lone C does not commit.
    drive(2'b01, 4'hA);
    drive(2'b10, 4'hB);
    chk("mid_locked", {31'd0, locked}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_outs", {20'd0, out_a, out_b, out_c}, 32'd0);
    chk("async_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("async_flags", {29'd0, frame_valid, seq_err, locked}, 32'd0);
    exp_cnt = 8'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    fv_base = fv_seen;
    drive(2'b00, 4'hC);
    drive(2'b11, 4'd0);
    settle();
    chk("lone_c_no_commit", fv_seen - fv_base, 32'd0);
    chk("lone_c_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("lone_c_locked", {31'd0, locked}, 32'd0);

    // Wrap: 256 good frames bring frame_cnt back to 0 on the last commit.
    fv_base  = fv_seen;
    err_base = err_seen;
    for (int i = 0; i < 256; i++)
      frame(4'(i), 4'(i + 5), 4'(i + 11));
    settle();
    chk("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("wrap_fv_count", fv_seen - fv_base, 32'd256);
    chk("wrap_no_err", err_seen - err_base, 32'd0);
    chk("wrap_outs", {20'd0, out_a, out_b, out_c}, 32'hF4A);

    drive(2'b11, 4'd0);
    drive(2'b11, 4'd0);
    settle();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
